// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: computes diff = a - b - bin over WIDTH bits,
// one 4-bit nibble per clock, least significant nibble first. Each nibble
// is formed by a 4-bit lookahead borrow network on a + ~b + ~borrow. The
// borrow is registered between nibbles.
//
// Handshake: an operation is accepted on a rising edge where
// start_valid && start_ready. start_ready is high only in IDLE. A start
// that arrives while busy is neither accepted nor queued, and the operand
// inputs are ignored during RUN. done is a one-cycle pulse. diff/bout/ovf
// are valid while done is high and hold until the next completion or reset.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             done,
   output logic             busy,
   output logic             dbg_state
);

   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [3:0] a_nib, b_inv, p, g, c;
   logic       c4;
   logic [3:0] nib_diff;
   logic       nib_bout;

   // Nibble selected by the index and the lookahead borrow network for it.
   always_comb begin
      a_nib = a_q[{idx_q, 2'b00} +: 4];
      b_inv = ~b_q[{idx_q, 2'b00} +: 4];
      p     = a_nib ^ b_inv;
      g     = a_nib & b_inv;
      c[0]  = ~borrow_q;
      c[1]  = g[0] | (p[0] & c[0]);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c[0]);
      c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c[0]);
      nib_diff = p ^ c;
      nib_bout = ~c4;
   end

   // Next-state logic: accept in IDLE, one nibble per cycle in RUN.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      res_d    = res_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               idx_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            res_d[{idx_q, 2'b00} +: 4] = nib_diff;
            borrow_d = nib_bout;
            idx_d    = idx_q + IW'(1);
            if (idx_q == LAST) begin
               // Publish only complete results so diff never shows partial nibbles.
               diff_d  = res_d;
               bout_d  = nib_bout;
               ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res_d[WIDTH-1] ^ a_q[WIDTH-1]);
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         res_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign start_ready = ~busy;
   assign dbg_state   = state_q;
   assign diff        = diff_q;
   assign bout        = bout_q;
   assign ovf         = ovf_q;
   assign done        = done_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Testbench for nibble_serial_subtractor (WIDTH=16): directed cases with
// cycle-exact timing checks, random operations with operands toggled during
// RUN, and a scoreboard that predicts every done result from a - b - bin.
module tb_nibble_serial_subtractor;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;
   logic         done;
   logic         busy;
   logic         dbg_state;

   int errors = 0;
   int checks = 0;

   // Expected {bout, ovf, diff} for each accepted operation, in order.
   logic [W+1:0] exp_q[$];

   nibble_serial_subtractor #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .bin         (bin),
      .diff        (diff),
      .bout        (bout),
      .ovf         (ovf),
      .done        (done),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's definition.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
      int          d_int;
      logic [W-1:0] d;
      logic        bo;
      logic        ov;
      d_int = int'(ma) - int'(mb) - int'(mbin);
      d     = W'(d_int + 65536 * 2);
      bo    = (int'(ma) < int'(mb) + int'(mbin));
      ov    = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
      return {bo, ov, d};
   endfunction

   // Scoreboard: inputs and start_ready are stable at the falling edge, so
   // what is seen here is exactly what the next rising edge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_done", 32'(done), 32'd0);
            end else begin
               logic [W+1:0] e;
               e = exp_q.pop_front();
               check("sb_diff", 32'(diff), 32'(e[W-1:0]));
               check("sb_bout", 32'(bout), 32'(e[W+1]));
               check("sb_ovf",  32'(ovf),  32'(e[W]));
            end
         end
         if (start_valid && start_ready)
            exp_q.push_back(model(a, b, bin));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
      @(posedge clk); #2;
      start_valid = 1'b1;
      a   = va;
      b   = vb;
      bin = vbin;
   endtask

   // Check the status outputs for one cycle of RUN (sampled #2 after an edge).
   task automatic check_running(input string tag);
      check({tag, "_busy"},  32'(busy), 32'd1);
      check({tag, "_ready"}, 32'(start_ready), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
   endtask

   // One complete operation with exact-latency checks; operands are
   // scrambled during RUN to show they are ignored.
   task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vbin);
      logic [W+1:0] e;
      e = model(va, vb, vbin);
      drive_start(va, vb, vbin);
      check({tag, "_ready_pre"}, 32'(start_ready), 32'd1);
      @(posedge clk); #2;                        // E0
      start_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge clk); #2;                  // E1..E3
         end
         a   = W'($urandom());
         b   = W'($urandom());
         bin = 1'($urandom_range(0, 1));
         if (k < 4) check_running(tag);
      end
      @(posedge clk); #2;                        // E4
      check({tag, "_done"},  32'(done), 32'd1);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_diff"},  32'(diff), 32'(e[W-1:0]));
      check({tag, "_bout"},  32'(bout), 32'(e[W+1]));
      check({tag, "_ovf"},   32'(ovf),  32'(e[W]));
      @(posedge clk); #2;                        // E5
      check({tag, "_done_fall"}, 32'(done), 32'd0);
      check({tag, "_hold"},      32'(diff), 32'(e[W-1:0]));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      a   = '0;
      b   = '0;
      bin = 1'b0;
      #12;
      check("rst_diff",  32'(diff), 32'd0);
      check("rst_bout",  32'(bout), 32'd0);
      check("rst_ovf",   32'(ovf),  32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      check("rst_ready", 32'(start_ready), 32'd1);

      // Directed cases with values worked out by hand.
      run_op("basic", 16'h1234, 16'h0234, 1'b0);
      check("basic_const", 32'(diff), 32'h1000);
      run_op("uflow", 16'h0000, 16'h0001, 1'b0);
      check("uflow_const", 32'({bout, ovf, diff}), 32'({1'b1, 1'b0, 16'hFFFF}));
      run_op("ovf1", 16'h8000, 16'h0001, 1'b0);
      check("ovf1_const", 32'({bout, ovf, diff}), 32'({1'b0, 1'b1, 16'h7FFF}));
      run_op("ovf2", 16'h7FFF, 16'hFFFF, 1'b0);
      check("ovf2_const", 32'({bout, ovf, diff}), 32'({1'b1, 1'b1, 16'h8000}));

      // Back-to-back with start_valid held high.
      drive_start(16'h0005, 16'h0005, 1'b1);
      @(posedge clk); #2;                        // E0 of first op
      for (int k = 0; k < 3; k++) begin
         a = W'($urandom()); b = W'($urandom());
         @(posedge clk); #2;
      end
      a = 16'hFFFF; b = 16'h0F0F; bin = 1'b0;    // second op presented
      @(posedge clk); #2;                        // E4: first done
      check("b2b_done1",  32'(done), 32'd1);
      check("b2b_res1",   32'({bout, ovf, diff}), 32'({1'b1, 1'b0, 16'hFFFF}));
      check("b2b_ready1", 32'(start_ready), 32'd1);
      @(posedge clk); #2;                        // second op accepted here
      check("b2b_accept", 32'(busy), 32'd1);
      start_valid = 1'b0;
      n = 0;
      while (!done && n < 10) begin
         a = W'($urandom()); b = W'($urandom());
         @(posedge clk); #2;
         n++;
      end
      check("b2b_latency", 32'(n), 32'd4);
      check("b2b_res2",    32'({bout, ovf, diff}), 32'({1'b0, 1'b0, 16'hF0F0}));

      // Reset in the middle of a run.
      drive_start(16'h1234, 16'h0001, 1'b0);
      @(posedge clk); #2;                        // E0
      start_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_diff", 32'(diff), 32'd0);
      check("mid_rst_flags", 32'({bout, ovf, done, busy}), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      check("mid_rst_ready", 32'(start_ready), 32'd1);
      repeat (6) begin
         @(posedge clk); #2;
         check("mid_rst_no_done", 32'(done), 32'd0);
      end
      run_op("post_rst", 16'h1234, 16'h0001, 1'b0);

      // Randomized operations, biased a little toward edge values.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom());
         rb = W'($urandom());
         if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
         if ($urandom_range(0, 7) == 0) rb = 16'h0000;
         if ($urandom_range(0, 7) == 0) rb = ra;
         run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
      end

      @(posedge clk); #2;
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
